// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM for the computer datapath.
// Each instruction goes FETCH -> DECODE -> EXEC -> (MEM) -> WB. The block
// emits one-cycle strobes for IR load, PC update and register-file write,
// and runs a data-memory req/ack handshake with a wait timeout. It also
// provides run/step/halt debug control and cycle/retire counters.
//
// Ports
//   clk       in   clock, rising edge
//   rstd      in   synchronous active-high reset
//   run       in   level, free-run instructions
//   step      in   pulse, one instruction while run=0 (sampled in IDLE only)
//   opcode    in   ins[31:26] from fetch
//   dmem_ack  in   data memory completed the current request
//   ir_ld     out  FETCH strobe
//   pc_wren   out  WB strobe, commit nextpc
//   rf_wren   out  WB strobe, register write (not for stores)
//   dmem_req  out  registered data memory request, held until ack
//   dmem_we   out  registered write qualifier for dmem_req
//   halted    out  sequencer is in HALT
//   fault     out  sticky MEM timeout flag
//   state     out  IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6
//   cycles    out  clocks spent outside IDLE/HALT
//   retired   out  completed instructions
//
// state  | meaning
// IDLE   | waiting for run or step
// FETCH  | ir_ld, opcode captured at end of cycle
// DECODE | HALT opcode detection
// EXEC   | select MEM or WB path
// MEM    | dmem_req held until ack or timeout
// WB     | pc_wren / rf_wren, retire
// HALT   | stopped until reset
module cpu_sequencer #(
  parameter logic [5:0] OP_LW   = 6'd16,
  parameter logic [5:0] OP_SW   = 6'd24,
  parameter logic [5:0] OP_HALT = 6'd63,
  parameter int         TO_W    = 4,
  parameter int         CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rstd,
  input  logic             run,
  input  logic             step,
  input  logic [5:0]       opcode,
  input  logic             dmem_ack,
  output logic             ir_ld,
  output logic             pc_wren,
  output logic             rf_wren,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  // wait_cnt counts MEM cycles already spent without ack; the cycle on
  // which it equals WAIT_LAST is the last one (2**TO_W-1 waits in total).
  localparam logic [TO_W-1:0] WAIT_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  state_t          cur, nxt;
  logic [5:0]      op_q;
  logic [TO_W-1:0] wait_cnt;
  logic            timeout;
  logic            mem_op;

  assign mem_op = (op_q == OP_LW) || (op_q == OP_SW);

  always_comb begin
    nxt     = cur;
    timeout = 1'b0;
    case (cur)
      S_IDLE:   if (run || step) nxt = S_FETCH;
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: nxt = (op_q == OP_HALT) ? S_HALT : S_EXEC;
      S_EXEC:   nxt = mem_op ? S_MEM : S_WB;
      S_MEM: begin
        // an ack on the final wait cycle takes priority over the timeout
        if (dmem_ack) begin
          nxt = S_WB;
        end else if (wait_cnt == WAIT_LAST) begin
          nxt     = S_HALT;
          timeout = 1'b1;
        end
      end
      S_WB:     nxt = run ? S_FETCH : S_IDLE;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstd) begin
      cur      <= S_IDLE;
      op_q     <= 6'd0;
      wait_cnt <= '0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      fault    <= 1'b0;
      cycles   <= '0;
      retired  <= '0;
    end else begin
      cur <= nxt;
      if (cur == S_FETCH) op_q <= opcode;
      wait_cnt <= (cur == S_MEM) ? wait_cnt + TO_W'(1) : '0;
      // request registered from next state so it is high for every MEM cycle
      dmem_req <= (nxt == S_MEM);
      dmem_we  <= (nxt == S_MEM) && (op_q == OP_SW);
      if (timeout) fault <= 1'b1;
      if (cur != S_IDLE && cur != S_HALT) cycles <= cycles + CNT_W'(1);
      if (cur == S_WB) retired <= retired + CNT_W'(1);
    end
  end

  assign state   = cur;
  assign ir_ld   = (cur == S_FETCH);
  assign pc_wren = (cur == S_WB);
  assign rf_wren = (cur == S_WB) && (op_q != OP_SW);
  assign halted  = (cur == S_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: self-checking bench for cpu_sequencer.
// Instructions are expanded into an expected per-cycle phase list
// (FETCH, DECODE, EXEC, MEM x n, WB) from the instruction-level rules.
// The list drives opcode and ack and supplies the expected outputs and counters.
module tb_cpu_sequencer;

  localparam logic [5:0] OP_LW   = 6'd16;
  localparam logic [5:0] OP_SW   = 6'd24;
  localparam logic [5:0] OP_HALT = 6'd63;
  localparam int         WAITS   = 15;

  logic        clk = 1'b0;
  logic        rstd, run, step, dmem_ack;
  logic [5:0]  opcode;
  logic        ir_ld, pc_wren, rf_wren, dmem_req, dmem_we, halted, fault;
  logic [2:0]  state;
  logic [31:0] cycles, retired;

  cpu_sequencer dut (
    .clk(clk), .rstd(rstd), .run(run), .step(step), .opcode(opcode),
    .dmem_ack(dmem_ack), .ir_ld(ir_ld), .pc_wren(pc_wren), .rf_wren(rf_wren),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .halted(halted), .fault(fault),
    .state(state), .cycles(cycles), .retired(retired)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // schedule: one entry per expected clock of the instruction stream
  int         q_state[$];
  logic [5:0] q_op[$];
  bit         q_ack[$];
  int         sched_end;
  bit         sched_fault;

  // reference counters
  logic [31:0] m_cycles, m_retired;
  bit          m_fault;

  task automatic sched_clear();
    q_state.delete(); q_op.delete(); q_ack.delete();
    sched_end = 0; sched_fault = 0;
  endtask

  task automatic push(input int s, input logic [5:0] op, input bit ack);
    q_state.push_back(s); q_op.push_back(op); q_ack.push_back(ack);
  endtask

  // d = MEM cycles before ack (ack on MEM cycle d+1); d >= WAITS means never
  task automatic add_instr(input logic [5:0] op, input int d);
    push(1, op, 1'($urandom_range(0, 1)));
    push(2, op, 1'($urandom_range(0, 1)));
    if (op == OP_HALT) begin
      sched_end = 6;
      return;
    end
    push(3, op, 1'($urandom_range(0, 1)));
    if (op == OP_LW || op == OP_SW) begin
      if (d >= WAITS) begin
        for (int k = 0; k < WAITS; k++) push(4, op, 1'b0);
        sched_end = 6; sched_fault = 1;
        return;
      end
      for (int k = 0; k <= d; k++) push(4, op, k == d);
    end
    push(5, op, 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    rstd = 1'b1; run = 1'b0; step = 1'b0; dmem_ack = 1'b0; opcode = 6'd0;
    @(negedge clk); @(negedge clk);
    rstd = 1'b0;
    m_cycles = 32'd0; m_retired = 32'd0; m_fault = 0;
  endtask

  task automatic test_reset();
    checks++;
    if ({state, ir_ld, pc_wren, rf_wren, dmem_req, dmem_we, halted, fault} !== 10'd0)
      begin errors++; $display("FAIL reset_outputs: got state=%0d strobes=%b%b%b%b%b h=%b f=%b want all 0",
        state, ir_ld, pc_wren, rf_wren, dmem_req, dmem_we, halted, fault); end
    checks++;
    if (cycles !== 32'd0 || retired !== 32'd0)
      begin errors++; $display("FAIL reset_counters: got cycles=%0d retired=%0d want 0 0", cycles, retired); end
  endtask

  // plays the current schedule in run mode; run drops during the last instruction
  task automatic test_program(input string name);
    int last_start = 0;
    logic [5:0] exp_str;
    foreach (q_state[k]) if (q_state[k] == 1) last_start = k;
    run = 1'b1; step = 1'b0;
    for (int i = 0; i < q_state.size(); i++) begin
      @(negedge clk);
      exp_str = {q_state[i] == 1, q_state[i] == 5, q_state[i] == 5 && q_op[i] != OP_SW,
                 q_state[i] == 4, q_state[i] == 4 && q_op[i] == OP_SW, q_state[i] == 6};
      checks++;
      if (state !== 3'(q_state[i]))
        begin errors++; $display("FAIL %s_state[%0d]: got %0d want %0d", name, i, state, q_state[i]); end
      checks++;
      if ({ir_ld, pc_wren, rf_wren, dmem_req, dmem_we, halted} !== exp_str)
        begin errors++; $display("FAIL %s_strobes[%0d]: got %b want %b", name, i,
          {ir_ld, pc_wren, rf_wren, dmem_req, dmem_we, halted}, exp_str); end
      checks++;
      if (cycles !== m_cycles || retired !== m_retired || fault !== m_fault)
        begin errors++; $display("FAIL %s_counters[%0d]: got c=%0d r=%0d f=%b want c=%0d r=%0d f=%b",
          name, i, cycles, retired, fault, m_cycles, m_retired, m_fault); end
      m_cycles = m_cycles + 32'd1;
      if (q_state[i] == 5) m_retired = m_retired + 32'd1;
      opcode = q_op[i]; dmem_ack = q_ack[i];
      if (i == last_start) run = 1'b0;
    end
    if (sched_fault) m_fault = 1;
    @(negedge clk);
    dmem_ack = 1'b0;
    checks++;
    if (state !== 3'(sched_end) || halted !== (sched_end == 6) || fault !== m_fault)
      begin errors++; $display("FAIL %s_end: got state=%0d h=%b f=%b want state=%0d f=%b",
        name, state, halted, fault, sched_end, m_fault); end
    checks++;
    if (cycles !== m_cycles || retired !== m_retired)
      begin errors++; $display("FAIL %s_end_counters: got c=%0d r=%0d want c=%0d r=%0d",
        name, cycles, retired, m_cycles, m_retired); end
  endtask

  // single-step one instruction; a second step pulse mid-instruction is ignored
  task automatic test_step(input logic [5:0] op, input int d);
    sched_clear();
    add_instr(op, d);
    run = 1'b0; step = 1'b1;
    for (int i = 0; i < q_state.size(); i++) begin
      @(negedge clk);
      checks++;
      if (state !== 3'(q_state[i]) || pc_wren !== (q_state[i] == 5))
        begin errors++; $display("FAIL step_state[%0d]: got %0d pc_wren=%b want %0d", i, state, pc_wren, q_state[i]); end
      m_cycles = m_cycles + 32'd1;
      if (q_state[i] == 5) m_retired = m_retired + 32'd1;
      opcode = q_op[i]; dmem_ack = q_ack[i];
      step = (i == 1);
    end
    dmem_ack = 1'b0; step = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (state !== 3'd0 || retired !== m_retired || cycles !== m_cycles)
        begin errors++; $display("FAIL step_idle: got state=%0d r=%0d c=%0d want 0 r=%0d c=%0d",
          state, retired, cycles, m_retired, m_cycles); end
    end
  endtask

  // HALT must hold regardless of run/step/ack until reset
  task automatic test_halt_hold(input string name);
    run = 1'b1; step = 1'b1; dmem_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (state !== 3'd6 || halted !== 1'b1 || retired !== m_retired || cycles !== m_cycles || pc_wren !== 1'b0)
        begin errors++; $display("FAIL %s_hold: got state=%0d h=%b r=%0d c=%0d want 6 1 r=%0d c=%0d",
          name, state, halted, retired, cycles, m_retired, m_cycles); end
    end
    run = 1'b0; step = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic test_random_program(input int n);
    logic [5:0] op;
    sched_clear();
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 2))
        0: begin
          do op = 6'($urandom_range(0, 62)); while (op == OP_LW || op == OP_SW);
        end
        1: op = OP_LW;
        default: op = OP_SW;
      endcase
      add_instr(op, int'($urandom_range(0, 5)));
    end
    test_program("random");
  endtask

  task automatic test_reset_mid_mem();
    opcode = OP_LW; run = 1'b1; dmem_ack = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (pc_wren !== 1'b0 || rf_wren !== 1'b0)
        begin errors++; $display("FAIL midrst_nowb: got pc_wren=%b rf_wren=%b want 0 0", pc_wren, rf_wren); end
    end
    checks++;
    if (state !== 3'd4 || dmem_req !== 1'b1)
      begin errors++; $display("FAIL midrst_inmem: got state=%0d req=%b want 4 1", state, dmem_req); end
    rstd = 1'b1; run = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || dmem_req !== 1'b0 || dmem_we !== 1'b0 || cycles !== 32'd0 || retired !== 32'd0 || pc_wren !== 1'b0)
      begin errors++; $display("FAIL midrst_after: got state=%0d req=%b c=%0d r=%0d want 0 0 0 0",
        state, dmem_req, cycles, retired); end
    rstd = 1'b0;
    m_cycles = 32'd0; m_retired = 32'd0; m_fault = 0;
  endtask

  initial begin
    do_reset();
    test_reset();

    sched_clear();
    repeat (3) add_instr(6'd0, 0);
    test_program("alu");

    sched_clear();
    add_instr(OP_LW, 2);
    test_program("lw");

    sched_clear();
    add_instr(OP_SW, 0);
    test_program("sw");

    test_random_program(20);

    test_step(6'd5, 0);
    test_step(OP_LW, 1);

    sched_clear();
    add_instr(OP_LW, WAITS - 1);
    test_program("ack_wins");

    sched_clear();
    add_instr(OP_SW, 0);
    add_instr(OP_LW, WAITS);
    test_program("timeout");
    test_halt_hold("timeout");

    do_reset();
    test_reset();
    sched_clear();
    add_instr(6'd1, 0);
    add_instr(OP_HALT, 0);
    test_program("halt");
    test_halt_hold("halt");

    do_reset();
    test_reset_mid_mem();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
